// File: rtl/la_pkg.sv
// rtl/la_pkg.sv - shared state encoding and trigger compare helper for la_capture
package la_pkg;

    localparam int LA_STATE_W = 2;
    localparam int LA_MAX_W   = 64;

    typedef enum logic [LA_STATE_W-1:0] {
        LA_IDLE    = 2'd0,
        LA_ARMED   = 2'd1,
        LA_CAPTURE = 2'd2,
        LA_DONE    = 2'd3
    } la_state_e;

    // Callers zero-extend to LA_MAX_W; unused high bits have a zero mask.
    function automatic logic la_trig_match(
        input logic [LA_MAX_W-1:0] i_sample,
        input logic [LA_MAX_W-1:0] i_mask,
        input logic [LA_MAX_W-1:0] i_value
    );
        return ((i_sample ^ i_value) & i_mask) == '0;
    endfunction

endpackage

// File: rtl/la_mem.sv
// rtl/la_mem.sv - sample buffer: one sync write port, one registered read port
module la_mem #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/la_capture.sv
// rtl/la_capture.sv - logic-analyser capture FSM; LA_PRETRIG_EN adds circular pre-trigger capture
module la_capture
    import la_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] sample_in,
    input  logic [WIDTH-1:0] trig_mask,
    input  logic [WIDTH-1:0] trig_value,
    input  logic             arm,
    input  logic             abort,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             rd_empty,
    output logic [1:0]       state,
    output logic [CW-1:0]    count
`ifdef LA_PRETRIG_EN
    ,
    output logic [AW-1:0]    trig_idx
`endif
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    la_state_e      r_state;
    la_state_e      w_next_state;
    logic [AW-1:0]  r_wr_ptr;
    logic [CW-1:0]  r_count;
    logic [CW-1:0]  r_rd_cnt;
    logic           r_rd_valid;
    logic           r_rd_empty;
    logic           w_match;
    logic           w_clear;
    logic           w_wr_en;
    logic           w_trig;
    logic           w_rd_fire;
    logic [AW-1:0]  w_rd_base;
    logic [AW-1:0]  w_rd_addr;

`ifdef LA_PRETRIG_EN
    localparam logic [CW-1:0] HALF = CW'(DEPTH / 2);
    logic [CW-1:0]  r_post;
    logic [AW-1:0]  r_trig_ptr;

    // Once the ring has wrapped, the oldest sample sits at the write pointer.
    assign w_rd_base = (r_count == FULL) ? r_wr_ptr : '0;
    assign trig_idx  = r_trig_ptr - w_rd_base;
`else
    assign w_rd_base = '0;
`endif

    assign w_match   = la_trig_match(LA_MAX_W'(sample_in), LA_MAX_W'(trig_mask),
                                     LA_MAX_W'(trig_value));
    assign w_rd_addr = w_rd_base + r_rd_cnt[AW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LA_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_wr_en      = 1'b0;
        w_trig       = 1'b0;
        w_rd_fire    = 1'b0;
        case (r_state)
            LA_IDLE: begin
                w_clear = 1'b1;
                if (arm) begin
                    w_next_state = LA_ARMED;
                end
            end
            LA_ARMED: begin
                if (ena) begin
`ifdef LA_PRETRIG_EN
                    w_wr_en = 1'b1;
`endif
                    if (w_match) begin
                        w_wr_en      = 1'b1;
                        w_trig       = 1'b1;
                        w_next_state = LA_CAPTURE;
                    end
                end
            end
            LA_CAPTURE: begin
`ifdef LA_PRETRIG_EN
                if (r_post == HALF) begin
`else
                if (r_count == FULL) begin
`endif
                    w_next_state = LA_DONE;
                end else if (ena) begin
                    w_wr_en = 1'b1;
                end
            end
            LA_DONE: begin
                if (arm) begin
                    w_next_state = LA_ARMED;
                    w_clear      = 1'b1;
                end else if (rd_en && (r_rd_cnt < r_count)) begin
                    w_rd_fire = 1'b1;
                end
            end
            default: w_next_state = LA_IDLE;
        endcase
        if (abort) begin
            w_next_state = LA_IDLE;
            w_clear      = 1'b1;
            w_wr_en      = 1'b0;
            w_trig       = 1'b0;
            w_rd_fire    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_rd_cnt   <= '0;
            r_rd_valid <= 1'b0;
            r_rd_empty <= 1'b0;
`ifdef LA_PRETRIG_EN
            r_post     <= '0;
            r_trig_ptr <= '0;
`endif
        end else begin
            r_rd_valid <= w_rd_fire;
            // Registered so empty rises the cycle after the last rd_valid.
            r_rd_empty <= (r_state == LA_DONE) && (w_next_state == LA_DONE) &&
                          (r_rd_cnt == r_count);
            if (w_clear) begin
                r_wr_ptr <= '0;
                r_count  <= '0;
                r_rd_cnt <= '0;
`ifdef LA_PRETRIG_EN
                r_post   <= '0;
`endif
            end else begin
                if (w_wr_en) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                    if (r_count != FULL) begin
                        r_count <= r_count + CW'(1);
                    end
                end
                if (w_rd_fire) begin
                    r_rd_cnt <= r_rd_cnt + CW'(1);
                end
`ifdef LA_PRETRIG_EN
                if (w_trig) begin
                    r_trig_ptr <= r_wr_ptr;
                    r_post     <= CW'(1);
                end else if (w_wr_en && (r_state == LA_CAPTURE)) begin
                    r_post <= r_post + CW'(1);
                end
`endif
            end
        end
    end

    la_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (sample_in),
        .i_rd_en   (w_rd_fire),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (rd_data)
    );

    assign rd_valid = r_rd_valid;
    assign rd_empty = r_rd_empty;
    assign state    = r_state;
    assign count    = r_count;

endmodule

// File: tb/tb_la_capture.sv
// tb/tb_la_capture.sv - directed self-checking bench for la_capture (LA_PRETRIG_EN aware)
`timescale 1ns/1ps
module tb_la_capture;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] sample_in;
    logic [7:0] trig_mask;
    logic [7:0] trig_value;
    logic       arm;
    logic       abort;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_empty;
    logic [1:0] state;
    logic [4:0] count;
`ifdef LA_PRETRIG_EN
    logic [3:0] trig_idx;
`endif

    int         n_total = 0;
    int         n_bad   = 0;
    int         n;
    logic [7:0] v;
    logic [7:0] exp_d;

    always #5 clk = ~clk;

    la_capture #(
        .WIDTH (8),
        .DEPTH (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .sample_in  (sample_in),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .arm        (arm),
        .abort      (abort),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_empty   (rd_empty),
        .state      (state),
        .count      (count)
`ifdef LA_PRETRIG_EN
        ,
        .trig_idx   (trig_idx)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ena = 1'b1; arm = 1'b0; abort = 1'b0; rd_en = 1'b0;
        sample_in = 8'h00; trig_mask = 8'h00; trig_value = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_state",    32'(state),    32'd0);
        check("rst_count",    32'(count),    32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data",  32'(rd_data),  32'd0);
        check("rst_rd_empty", 32'(rd_empty), 32'd0);
        tick;
        check("idle_hold", 32'(state), 32'd0);

`ifndef LA_PRETRIG_EN
        // masked trigger on upper nibble, ramp from 0x00
        trig_mask = 8'hF0; trig_value = 8'hA0; v = 8'h00; sample_in = v;
        arm = 1'b1; tick; arm = 1'b0;
        check("arm_to_armed", 32'(state), 32'd1);
        n = 0;
        while (state == 2'd1 && n < 300) begin
            v++; sample_in = v; tick; n++;
        end
        check("mtrig_state", 32'(state), 32'd2);
        check("mtrig_count", 32'(count), 32'd1);
        check("mtrig_value", 32'(v),     32'hA0);
        n = 0;
        while (state == 2'd2 && n < 100) begin
            v++; sample_in = v; tick; n++;
        end
        check("mtrig_done_lat",   32'(n),        32'd16);
        check("mtrig_done_state", 32'(state),    32'd3);
        check("mtrig_done_count", 32'(count),    32'd16);
        check("mtrig_not_empty",  32'(rd_empty), 32'd0);
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick;
            exp_d = 8'hA0 + 8'(i);
            check($sformatf("mtrig_rv%0d", i), 32'(rd_valid), 32'd1);
            check($sformatf("mtrig_rd%0d", i), 32'(rd_data),  32'(exp_d));
            check($sformatf("mtrig_re%0d", i), 32'(rd_empty), 32'd0);
        end
        tick;
        check("empty_rd_valid", 32'(rd_valid), 32'd0);
        check("empty_flag",     32'(rd_empty), 32'd1);
        tick;
        check("empty_rd_valid2", 32'(rd_valid), 32'd0);
        check("empty_flag2",     32'(rd_empty), 32'd1);
        rd_en = 1'b0;

        // zero mask triggers on the first enabled ARMED edge
        trig_mask = 8'h00;
        arm = 1'b1; tick; arm = 1'b0;
        check("imm_armed", 32'(state),    32'd1);
        check("imm_clear", 32'(count),    32'd0);
        check("imm_empty", 32'(rd_empty), 32'd0);
        sample_in = 8'h5C; tick;
        check("imm_capture", 32'(state), 32'd2);
        check("imm_count",   32'(count), 32'd1);
        n = 0;
        while (state == 2'd2 && n < 100) begin
            sample_in = n[7:0]; tick; n++;
        end
        check("imm_done", 32'(state), 32'd3);
        rd_en = 1'b1; tick; rd_en = 1'b0;
        check("imm_rv",    32'(rd_valid), 32'd1);
        check("imm_first", 32'(rd_data),  32'h5C);
        rd_en = 1'b1; arm = 1'b1; tick; rd_en = 1'b0; arm = 1'b0;
        check("arm_beats_rd_state", 32'(state),    32'd1);
        check("arm_beats_rd_rv",    32'(rd_valid), 32'd0);
        check("arm_beats_rd_count", 32'(count),    32'd0);

        // ena low for 5 cycles mid-capture
        v = 8'h10; sample_in = v; tick;
        check("gate_trig",  32'(state), 32'd2);
        check("gate_count", 32'(count), 32'd1);
        for (int i = 0; i < 3; i++) begin
            v++; sample_in = v; tick;
        end
        check("gate_pre_count", 32'(count), 32'd4);
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            v++; sample_in = v; tick;
            check($sformatf("gate_frozen%0d", i), 32'(count), 32'd4);
        end
        ena = 1'b1;
        n = 0;
        while (state == 2'd2 && n < 100) begin
            v++; sample_in = v; tick; n++;
        end
        check("gate_done_lat",   32'(n),     32'd13);
        check("gate_done_count", 32'(count), 32'd16);
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick;
            exp_d = (i < 4) ? 8'h10 + 8'(i) : 8'h19 + 8'(i - 4);
            check($sformatf("gate_rd%0d", i), 32'(rd_data), 32'(exp_d));
        end
        rd_en = 1'b0;
`endif

        // abort and priority rules
        abort = 1'b1; tick; abort = 1'b0;
        check("abort_idle",  32'(state), 32'd0);
        check("abort_count", 32'(count), 32'd0);
        arm = 1'b1; abort = 1'b1; tick; arm = 1'b0; abort = 1'b0;
        check("abort_beats_arm", 32'(state), 32'd0);
        trig_mask = 8'hFF; trig_value = 8'hEE; sample_in = 8'h00;
        arm = 1'b1; tick; arm = 1'b0;
        check("pri_armed", 32'(state), 32'd1);
        rd_en = 1'b1; tick; rd_en = 1'b0;
        check("rd_in_armed_rv",    32'(rd_valid), 32'd0);
        check("rd_in_armed_state", 32'(state),    32'd1);
        trig_mask = 8'h00; tick;
        check("pri_capture", 32'(state), 32'd2);
`ifdef LA_PRETRIG_EN
        check("pri_count", 32'(count), 32'd2);
`else
        check("pri_count", 32'(count), 32'd1);
`endif
        arm = 1'b1; tick; arm = 1'b0;
        check("arm_in_capture", 32'(state), 32'd2);
`ifdef LA_PRETRIG_EN
        check("arm_in_capture_count", 32'(count), 32'd3);
`else
        check("arm_in_capture_count", 32'(count), 32'd2);
`endif
        abort = 1'b1; tick; abort = 1'b0;
        check("abort_capture_state", 32'(state), 32'd0);
        check("abort_capture_count", 32'(count), 32'd0);

        // asynchronous reset mid-acquisition
        arm = 1'b1; tick; arm = 1'b0; tick; tick;
        check("pre_rst_capture", 32'(state), 32'd2);
        rst_n = 1'b0; #1;
        check("mid_rst_state",    32'(state),    32'd0);
        check("mid_rst_count",    32'(count),    32'd0);
        check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
        check("mid_rst_rd_data",  32'(rd_data),  32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        tick;
        check("post_rst_state", 32'(state), 32'd0);

`ifdef LA_PRETRIG_EN
        // pre-trigger: ramp with exact trigger on 0x40
        trig_mask = 8'hFF; trig_value = 8'h40; v = 8'h00; sample_in = v;
        arm = 1'b1; tick; arm = 1'b0;
        n = 0;
        while (state == 2'd1 && n < 300) begin
            v++; sample_in = v; tick; n++;
        end
        check("pt_trig_value", 32'(v),     32'h40);
        check("pt_state",      32'(state), 32'd2);
        check("pt_count_sat",  32'(count), 32'd16);
        n = 0;
        while (state == 2'd2 && n < 100) begin
            v++; sample_in = v; tick; n++;
        end
        check("pt_done_lat", 32'(n),        32'd8);
        check("pt_done",     32'(state),    32'd3);
        check("pt_trig_idx", 32'(trig_idx), 32'd8);
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick;
            exp_d = 8'h38 + 8'(i);
            check($sformatf("pt_rd%0d", i), 32'(rd_data), 32'(exp_d));
        end
        tick;
        check("pt_empty", 32'(rd_empty), 32'd1);
        rd_en = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/la_capture.md
# la_capture

Parametrised logic-analyser capture block for the Tiny Tapeout user-design slot. It samples a WIDTH-bit probe bus, waits for a masked trigger match, stores DEPTH samples in an internal buffer, then plays them back through a read strobe. It is the parametrised next generation of the fixed 8-bit pin-level harness. The top-level design wires `ui_in` to the probe bus, and the readout goes to `uo_out`.

## Interface
Parameters:
- WIDTH, 8, probe/sample width in bits (≥1)
- DEPTH, 16, buffer entries; power of two, ≥4

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design enable; low pauses sampling and triggering
- sample_in  in  WIDTH  probe bus, sampled on every enabled rising edge
- trig_mask  in  WIDTH  1 = bit participates in the trigger compare
- trig_value  in  WIDTH  trigger compare value
- arm  in  1  single-cycle request to start an acquisition
- abort  in  1  return to IDLE from any state
- rd_en  in  1  read strobe; honoured only in DONE
- rd_data  out  WIDTH  registered read data
- rd_valid  out  1  high for one cycle when rd_data is new
- rd_empty  out  1  high in DONE once all stored entries have been read
- state  out  2  current state: IDLE=0, ARMED=1, CAPTURE=2, DONE=3
- count  out  $clog2(DEPTH)+1  number of valid stored entries

## Operation
Trigger condition: `((sample_in ^ trig_value) & trig_mask) == 0`. An all-zero mask therefore triggers immediately.

State behaviour:
- **IDLE**: no writes. `arm` → ARMED. On entry, clear wr_ptr, rd_ptr and count.
- **ARMED**: on each cycle with `ena`=1, evaluate the trigger. On a match, write this sample to entry 0, set count=1 and go to CAPTURE.
- **CAPTURE**: on each cycle with `ena`=1, write `sample_in` at wr_ptr and increment wr_ptr and count. When count reaches DEPTH → DONE.
- **DONE**: on `rd_en` with rd_ptr<count, present entry rd_ptr, increment rd_ptr and pulse `rd_valid`. `arm` → ARMED, clearing the pointers and count.

Boundary and priority rules:
- `abort` → IDLE from any state. `abort` beats `arm` in the same cycle.
- `arm` is ignored in ARMED and CAPTURE.
- `rd_en` is ignored outside DONE. In DONE with rd_ptr==count it does nothing: rd_valid stays 0 and rd_empty stays 1.
- `ena`=0 freezes wr_ptr, count and the trigger evaluation. Reads in DONE still proceed.
- `rd_en` and `arm` together in DONE: `arm` wins and no read occurs.
- Reset mid-acquisition: all outputs take their reset values and buffer contents are undefined. The bench must not read stale data without a new acquisition.
- Counters saturate at DEPTH; no wrap-around in the default build.

## Timing
- Reset values: rd_data=0, rd_valid=0, rd_empty=0, state=IDLE, count=0.
- State transitions take effect on the edge after the causing input.
  - Example: `arm` sampled at edge N gives state=ARMED after edge N.
- The trigger sample is the one present at the edge where the match is seen, and it is stored as entry 0.
- Read latency is 1 cycle: rd_en at edge N gives rd_data/rd_valid valid after edge N, with rd_valid high for exactly that cycle.
- Back-to-back rd_en gives one entry per cycle.
- rd_empty is asserted in the cycle after the final read's rd_valid. It is also asserted immediately in DONE if count==0, which is unreachable in the default build.
- A full acquisition with constant `ena` takes DEPTH cycles from the trigger edge to DONE.

## Configuration
- **LA_PRETRIG_EN defined**:
  - ARMED writes every enabled sample circularly (wr_ptr wraps modulo DEPTH), and count saturates at DEPTH.
  - On trigger, CAPTURE writes DEPTH/2 samples, including the trigger sample, then goes to DONE.
  - Readout starts at the oldest entry (wr_ptr at DONE entry when count==DEPTH, otherwise 0) and proceeds modulo DEPTH.
  - An extra output `trig_idx` [$clog2(DEPTH)-1:0] gives the read index of the trigger sample, counted from the readout start.
- **LA_PRETRIG_EN undefined**: post-trigger-only behaviour as above; `trig_idx` does not exist.

## Structure
- Package `la_pkg` holds:
  - the state enum and its encodings (IDLE/ARMED/CAPTURE/DONE)
  - the state width constant
  - a helper function for the masked compare
- Sub-module `la_mem`: WIDTH×DEPTH register array with synchronous write, one write port and one registered read port. It has no reset on the array; only the read-data register resets.
- The top level contains the FSM, pointers, count and trigger compare.

## Test plan
Default parameters (WIDTH=8, DEPTH=16) unless stated.

- **Reset**: hold rst_n=0 for 3 cycles, then release → state=0, count=0, rd_valid=0, rd_data=0.
- **Masked trigger**: mask=0xF0, value=0xA0; arm; ramp sample_in from 0x00 upward each cycle.
  - Trigger fires at 0xA0.
  - DONE after 16 cycles with count=16.
  - 16 reads return 0xA0..0xAF, then rd_empty=1.
- **Immediate trigger**: mask=0x00; arm → CAPTURE on the next enabled edge, with the first stored entry equal to sample_in at that edge.
- **ena gating**: ena low for 5 cycles mid-CAPTURE → count frozen; the stored sequence skips those 5 samples; DONE is 5 cycles later.
- **Abort and priority**:
  - arm+abort in the same cycle in IDLE → stays IDLE.
  - abort mid-CAPTURE → IDLE, count=0.
  - rd_en in ARMED → rd_valid stays 0.
- **LA_PRETRIG_EN**: ramp 0x00.. with trigger value 0x40, mask 0xFF, armed ≥16 cycles before the trigger.
  - Readout is 0x38..0x47.
  - trig_idx=8.
